// File: rtl/toast_timer.sv
// Toaster countdown timer: BCD M:SS preset and countdown with pause/resume,
// plus a free-running 16-step PWM that drives the heater only while running.
module toast_timer #(
    parameter int          CLK_HZ     = 2000,
    parameter logic [11:0] PRESET_RST = 12'h100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        write,
    input  logic [11:0] set_time,
    input  logic [3:0]  duty,
    output logic [11:0] tLED,
    output logic        pwm,
    output logic        running,
    output logic        done
);

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [11:0]   preset_q, preset_d;
    logic [11:0]   count_q, count_d;
    logic [11:0]   tled_q, tled_d;
    logic [11:0]   count_dec;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    pwm_cnt_q, pwm_cnt_d;
    logic          pwm_q, pwm_d;
    logic          running_q, running_d;
    logic          done_q, done_d;

    function automatic logic bcd_valid(input logic [11:0] v);
        return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] m, t, u;
        m = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (u != 4'd0) begin
            u = u - 4'd1;
        end else begin
            u = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd5;
                m = m - 4'd1;
            end
        end
        return {m, t, u};
    endfunction

    assign count_dec = bcd_dec(count_q);

    always_comb begin
        state_d   = state_q;
        preset_d  = preset_q;
        count_d   = count_q;
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q + 4'd1;

        if (write && (state_q != RUN) && bcd_valid(set_time)) begin
            preset_d = set_time;
        end

        // A write in the same cycle as start wins; the new preset is used by the next start.
        case (state_q)
            IDLE, DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start && !write && (preset_q != 12'h000)) begin
                    state_d = RUN;
                    count_d = preset_q;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    count_d = count_dec;
                    if (count_dec == 12'h000) begin
                        state_d = DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start && !write) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE:    tled_d = preset_d;
            DONE:    tled_d = 12'h000;
            default: tled_d = count_d;
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        pwm_d     = (state_d == RUN) && (pwm_cnt_q < duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            preset_q  <= PRESET_RST;
            count_q   <= 12'h000;
            presc_q   <= '0;
            pwm_cnt_q <= 4'd0;
            tled_q    <= PRESET_RST;
            pwm_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            tled_q    <= tled_d;
            pwm_q     <= pwm_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tLED    = tled_q;
    assign pwm     = pwm_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: doc/toast_timer.md
TOAST_TIMER -- requirements
Module: toast_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 2000; clk cycles per one-second countdown tick.
REQ-002 SHALL have parameter PRESET_RST, default 12'h100; preset value loaded at reset (BCD M:SS = 1:00).
REQ-003 SHALL have port clk, input, 1; the single clock, 2 kHz from the PLL.
REQ-004 SHALL have port reset, input, 1; synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1; start/resume request, sampled each edge.
REQ-006 SHALL have port stop, input, 1; pause/cancel request, sampled each edge.
REQ-007 SHALL have port write, input, 1; load set_time into the preset register.
REQ-008 SHALL have port set_time, input, 12; BCD {minutes, seconds-tens, seconds-units}.
REQ-009 SHALL have port duty, input, 4; heater duty, in sixteenths.
REQ-010 SHALL have port tLED, output, 12; BCD time shown on the display (to segments/decode7).
REQ-011 SHALL have port pwm, output, 1; heater element drive.
REQ-012 SHALL have port running, output, 1; high in RUN.
REQ-013 SHALL have port done, output, 1; high in DONE.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-015 SHALL, in IDLE, drive tLED = preset; in DONE, drive tLED = 12'h000; in RUN and PAUSE, drive tLED = remaining count.
REQ-016 SHALL accept write only in IDLE, PAUSE or DONE, and only for valid BCD: minutes <= 9, tens <= 5, units <= 9.
REQ-017 SHALL ignore invalid writes and writes in RUN; the preset is left unchanged.
REQ-018 SHALL, on start in IDLE or DONE with preset != 0, load count = preset, clear the prescaler, and enter RUN on that edge.
REQ-019 SHALL ignore start with preset == 0.
REQ-020 SHALL, on start in PAUSE, resume RUN with count and prescaler unchanged.
REQ-021 SHALL move RUN->PAUSE on stop, PAUSE->IDLE on stop, and DONE->IDLE on stop.
REQ-022 SHALL give stop priority when stop and start are asserted in the same cycle.
REQ-023 SHALL give write priority over start in the same cycle; the new preset is used by the following start.
REQ-024 SHALL, in RUN, count the prescaler 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0 and decrements count once.
REQ-025 SHALL place the first decrement CLK_HZ cycles after the start edge.
REQ-026 SHALL decrement count in BCD: units 0 -> 9 with borrow; tens 0 -> 5 with borrow; minutes decrement.
REQ-027 SHALL, on the edge where count becomes 12'h000, enter DONE, set done = 1, clear running, and force pwm = 0.
REQ-028 SHALL free-run a 4-bit pwm counter (mod 16) in all states.
REQ-029 SHALL set pwm = 1 only in RUN and only while pwm_cnt < duty; duty = 0 means never, duty = 15 means 15/16.
REQ-030 SHALL hold pwm = 0 in IDLE, PAUSE and DONE.
REQ-031 SHALL take duty changes effect on the next cycle with no glitch beyond the registered compare.

Reset
REQ-032 SHALL, on reset, force state = IDLE, preset = PRESET_RST, count = 0, prescaler = 0, pwm_cnt = 0.
REQ-033 SHALL, after reset, drive outputs tLED = PRESET_RST, pwm = 0, running = 0, done = 0, from the next edge.
REQ-034 SHALL give reset priority over all inputs, including mid-RUN; there is no resume after reset.

Verification (CLK_HZ = 4)
REQ-035 SHALL verify: reset -> tLED = 12'h100, pwm = 0, running = 0, done = 0.
REQ-036 SHALL verify: write 12'h003, then start -> running = 1; tLED goes 003 -> 002 -> 001 at 4-cycle steps; at cycle 12, done = 1 and tLED = 000.
REQ-037 SHALL verify borrow: preset 12'h100, start -> tLED = 12'h059 after 4 cycles; preset 12'h010 -> 12'h009.
REQ-038 SHALL verify invalid writes: write 12'h07A or 12'h060 -> preset unchanged (tLED = 12'h100); write during RUN is ignored.
REQ-039 SHALL verify pause/resume: stop mid-RUN freezes tLED and drops pwm; start resumes from the same prescaler; stop twice -> IDLE with tLED = preset; start+stop together -> PAUSE.
REQ-040 SHALL verify duty and reset: duty = 4 in RUN -> pwm high 4 of every 16 cycles; reset asserted mid-RUN -> IDLE, running = 0 on the next edge.
